// File: rtl/change_dispenser_if.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser_if
// Description : Bundles the credit/refund request, coin hopper handshake,
//               per-refund result and restock/stock signals of the change
//               dispenser.
//               slave  - the dispenser side (drives results, coin offers, stock)
//               master - the credit accumulator / hopper driver side
// Revision    : 1.0 - initial release
// ============================================================================
interface change_dispenser_if #(
    parameter int CREDIT_W = 8,
    parameter int CNT_W    = 4,
    parameter int NDEN     = 5
);
    // Refund request from the credit accumulator
    logic                     refund;
    logic [CREDIT_W-1:0]      credit;
    logic                     busy;
    // Coin offer to the hopper driver
    logic                     coin_valid;
    logic [2:0]               coin_sel;
    logic                     coin_ready;
    // Per-refund result
    logic [NDEN*CNT_W-1:0]    counts;
    logic [CREDIT_W-1:0]      remainder;
    logic                     shortfall;
    logic                     done;
    // Hopper stock maintenance
    logic                     restock;
    logic [2:0]               restock_sel;
    logic [CNT_W-1:0]         restock_amt;
    logic [NDEN*CNT_W-1:0]    stock;

    modport slave (
        input  refund, credit, coin_ready, restock, restock_sel, restock_amt,
        output busy, coin_valid, coin_sel, counts, remainder, shortfall, done,
               stock
    );

    modport master (
        output refund, credit, coin_ready, restock, restock_sel, restock_amt,
        input  busy, coin_valid, coin_sel, counts, remainder, shortfall, done,
               stock
    );
endinterface
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser
// Description : Greedy largest-first coin change dispenser. A refund latches
//               the credit, then the FSM walks the denominations from the
//               largest down, offering one coin per valid/ready handshake to
//               the hopper while tracking hopper stock and per-refund counts.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - change_dispenser_if.slave (refund/credit/busy,
//                       coin_valid/coin_sel/coin_ready, counts/remainder/
//                       shortfall/done, restock/restock_sel/restock_amt/stock)
// Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int                     CREDIT_W   = 8,
    parameter int                     CNT_W      = 4,
    parameter int                     NDEN       = 5,
    parameter logic [NDEN*CREDIT_W-1:0] DENOMS   = {8'd100, 8'd50, 8'd20, 8'd10, 8'd5},
    parameter logic [CNT_W-1:0]       INIT_STOCK = 4'd15
) (
    input  logic               clk,
    input  logic               rst_n,
    change_dispenser_if.slave  bus
);

    localparam int               IDX_W   = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [CREDIT_W-1:0] rem_q,       rem_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic [CREDIT_W-1:0] remainder_q, remainder_d;
    logic                shortfall_q, shortfall_d;

    logic [CNT_W-1:0]    stock_q  [NDEN];
    logic [CNT_W-1:0]    stock_d  [NDEN];
    logic [CNT_W-1:0]    counts_q [NDEN];
    logic [CNT_W-1:0]    counts_d [NDEN];
    logic [CREDIT_W-1:0] w_denom  [NDEN];

    logic                  w_hs;
    logic                  w_clr;
    logic                  w_elig;
    logic [NDEN*CNT_W-1:0] w_stock_pk;
    logic [NDEN*CNT_W-1:0] w_counts_pk;

    // Unpack denominations and pack per-slot state onto the bus
    always_comb begin
        w_stock_pk  = '0;
        w_counts_pk = '0;
        for (int i = 0; i < NDEN; i++) begin
            w_denom[i]                    = DENOMS[i*CREDIT_W +: CREDIT_W];
            w_stock_pk[i*CNT_W +: CNT_W]  = stock_q[i];
            w_counts_pk[i*CNT_W +: CNT_W] = counts_q[i];
        end
    end

    assign w_hs   = (state_q == S_ISSUE) && bus.coin_ready;
    // A denomination at zero stock or at a saturated count cannot be issued
    assign w_elig = (rem_q >= w_denom[idx_q]) &&
                    (stock_q[idx_q] != '0) &&
                    (counts_q[idx_q] != CNT_MAX);

    // ------------------------------------------------------------------
    // FSM next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        remainder_d = remainder_q;
        shortfall_d = shortfall_q;
        w_clr       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.refund) begin
                    rem_d   = bus.credit;
                    idx_d   = IDX_W'(NDEN - 1);
                    w_clr   = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_elig) begin
                    state_d = S_ISSUE;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                end else begin
                    // Result is captured on entry so it is valid while done is high
                    remainder_d = rem_q;
                    shortfall_d = (rem_q != '0);
                    state_d     = S_DONE;
                end
            end
            S_ISSUE: begin
                if (bus.coin_ready) begin
                    rem_d   = rem_q - w_denom[idx_q];
                    state_d = S_SCAN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            idx_q       <= '0;
            remainder_q <= '0;
            shortfall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            remainder_q <= remainder_d;
            shortfall_q <= shortfall_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-denomination stock and count registers
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NDEN; i++) begin : g_slot
        logic             w_dec;
        logic             w_add;
        logic [CNT_W:0]   w_sum;

        assign w_dec = w_hs && (idx_q == IDX_W'(i));
        assign w_add = bus.restock && (bus.restock_sel == IDX_W'(i));

        // Computed one bit wider so a restock overflow can be clamped; the
        // decrement only happens on a non-empty slot so it never underflows.
        assign w_sum = {1'b0, stock_q[i]}
                     + (w_add ? {1'b0, bus.restock_amt} : {(CNT_W+1){1'b0}})
                     - {{CNT_W{1'b0}}, w_dec};

        assign stock_d[i]  = w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];
        assign counts_d[i] = w_clr ? '0 :
                             (w_dec ? counts_q[i] + CNT_W'(1) : counts_q[i]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stock_q[i]  <= INIT_STOCK;
                counts_q[i] <= '0;
            end else begin
                stock_q[i]  <= stock_d[i];
                counts_q[i] <= counts_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.coin_valid = (state_q == S_ISSUE);
    assign bus.coin_sel   = (state_q == S_ISSUE) ? idx_q : '0;
    assign bus.done       = (state_q == S_DONE);
    assign bus.remainder  = remainder_q;
    assign bus.shortfall  = shortfall_q;
    assign bus.counts     = w_counts_pk;
    assign bus.stock      = w_stock_pk;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_dispenser
// Description : Scoreboard bench for change_dispenser. Stimulus pushes the
//               expected coin sequence and refund result into queues; a
//               monitor pops and compares on every coin handshake and done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

    localparam int CREDIT_W = 8;
    localparam int CNT_W    = 4;
    localparam int NDEN     = 5;

    typedef struct packed {
        logic [NDEN*CNT_W-1:0] counts;
        logic [CREDIT_W-1:0]   rem;
        logic                  sh;
    } exp_t;

    logic clk;
    logic rst_n;

    change_dispenser_if #(.CREDIT_W(CREDIT_W), .CNT_W(CNT_W), .NDEN(NDEN)) bus ();

    change_dispenser #(
        .CREDIT_W   (CREDIT_W),
        .CNT_W      (CNT_W),
        .NDEN       (NDEN),
        .DENOMS     ({8'd100, 8'd50, 8'd20, 8'd10, 8'd5}),
        .INIT_STOCK (4'd15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   coin_q[$];
    exp_t done_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Monitor: pops scoreboard entries whenever the DUT presents output
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.coin_valid && bus.coin_ready) begin
                if (coin_q.size() == 0) begin
                    check("coin_unexpected", {29'd0, bus.coin_sel}, 32'hFFFF_FFFF);
                end else begin
                    check("coin_sel", {29'd0, bus.coin_sel}, coin_q.pop_front());
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", {31'd0, bus.done}, 32'd0);
                end else begin
                    exp_t e;
                    e = done_q.pop_front();
                    check("counts",    {12'd0, bus.counts}, {12'd0, e.counts});
                    check("remainder", {24'd0, bus.remainder}, {24'd0, e.rem});
                    check("shortfall", {31'd0, bus.shortfall}, {31'd0, e.sh});
                    check("busy_at_done", {31'd0, bus.busy}, 32'd1);
                    check("coins_left_at_done", coin_q.size(), 32'd0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic exp_coin(input int sel);
        coin_q.push_back(sel);
    endtask

    task automatic pulse_refund(input logic [CREDIT_W-1:0] c);
        @(posedge clk); #1;
        bus.refund = 1'b1;
        bus.credit = c;
        @(posedge clk); #1;
        bus.refund = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
        check("busy_after_done", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic run_refund(input logic [CREDIT_W-1:0] c,
                              input logic [NDEN*CNT_W-1:0] ecnt,
                              input logic [CREDIT_W-1:0] erem,
                              input logic esh);
        exp_t e;
        e.counts = ecnt;
        e.rem    = erem;
        e.sh     = esh;
        done_q.push_back(e);
        pulse_refund(c);
        wait_done(100);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic do_restock(input logic [2:0] sel, input logic [CNT_W-1:0] amt);
        @(posedge clk); #1;
        bus.restock     = 1'b1;
        bus.restock_sel = sel;
        bus.restock_amt = amt;
        @(posedge clk); #1;
        bus.restock = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.coin_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("valid_timeout", 32'd0, 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n           = 1'b0;
        bus.refund      = 1'b0;
        bus.credit      = '0;
        bus.coin_ready  = 1'b1;
        bus.restock     = 1'b0;
        bus.restock_sel = '0;
        bus.restock_amt = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   {31'd0, bus.busy}, 32'd0);
        check("rst_valid",  {31'd0, bus.coin_valid}, 32'd0);
        check("rst_done",   {31'd0, bus.done}, 32'd0);
        check("rst_short",  {31'd0, bus.shortfall}, 32'd0);
        check("rst_sel",    {29'd0, bus.coin_sel}, 32'd0);
        check("rst_counts", {12'd0, bus.counts}, 32'd0);
        check("rst_rem",    {24'd0, bus.remainder}, 32'd0);
        check("rst_stock",  {12'd0, bus.stock}, 32'h000F_FFFF);
        rst_n = 1'b1;

        // 185 -> 100+50+20+10+5
        exp_coin(4); exp_coin(3); exp_coin(2); exp_coin(1); exp_coin(0);
        run_refund(8'd185, 20'h11111, 8'd0, 1'b0);
        check("stock_185", {12'd0, bus.stock}, 32'h000E_EEEE);

        // Restock saturates at 15; out-of-range index is ignored
        do_restock(3'd4, 4'd5);
        check("restock_sat", {12'd0, bus.stock}, 32'h000F_EEEE);
        do_restock(3'd7, 4'd1);
        check("restock_oor", {12'd0, bus.stock}, 32'h000F_EEEE);

        // 40 -> 20+20
        exp_coin(2); exp_coin(2);
        run_refund(8'd40, 20'h00200, 8'd0, 1'b0);
        check("stock_40", {12'd0, bus.stock}, 32'h000F_ECEE);

        // 7 -> 5, 2 left over
        exp_coin(0);
        run_refund(8'd7, 20'h00001, 8'd2, 1'b1);
        check("stock_7", {12'd0, bus.stock}, 32'h000F_ECED);

        // 0 -> no coins
        run_refund(8'd0, 20'h00000, 8'd0, 1'b0);

        // Drain the 20 slot, then 40 must come out as four 10s
        do_reset();
        for (int n = 0; n < 15; n++) begin
            exp_coin(2);
            run_refund(8'd20, 20'h00100, 8'd0, 1'b0);
        end
        check("stock_drained", {12'd0, bus.stock}, 32'h000F_F0FF);
        exp_coin(1); exp_coin(1); exp_coin(1); exp_coin(1);
        run_refund(8'd40, 20'h00040, 8'd0, 1'b0);
        check("stock_no20", {12'd0, bus.stock}, 32'h000F_F0BF);

        // Bring stock[0] down to 5, then stall the hopper
        do_reset();
        for (int n = 0; n < 10; n++) begin
            exp_coin(0);
            run_refund(8'd5, 20'h00001, 8'd0, 1'b0);
        end
        check("stock_five", {12'd0, bus.stock}, 32'h000F_FFF5);
        begin
            exp_t e;
            e.counts = 20'h00001;
            e.rem    = 8'd0;
            e.sh     = 1'b0;
            done_q.push_back(e);
        end
        exp_coin(0);
        @(posedge clk); #1;
        bus.coin_ready = 1'b0;
        pulse_refund(8'd5);
        wait_valid(20);
        for (int k = 0; k < 3; k++) begin
            check("stall_valid",  {31'd0, bus.coin_valid}, 32'd1);
            check("stall_sel",    {29'd0, bus.coin_sel}, 32'd0);
            check("stall_counts", {12'd0, bus.counts}, 32'd0);
            check("stall_stock",  {12'd0, bus.stock}, 32'h000F_FFF5);
            @(posedge clk); #1;
            if (k == 0) begin
                // Refund while busy must be ignored
                bus.refund = 1'b1;
                bus.credit = 8'd100;
            end else if (k == 1) begin
                bus.refund = 1'b0;
            end else begin
                // Handshake and restock on the same slot in the same cycle
                bus.coin_ready  = 1'b1;
                bus.restock     = 1'b1;
                bus.restock_sel = 3'd0;
                bus.restock_amt = 4'd3;
            end
        end
        @(posedge clk); #1;
        bus.restock = 1'b0;
        wait_done(50);
        check("stock_hs_restock", {12'd0, bus.stock}, 32'h000F_FFF7);

        // Reset in the middle of a stalled offer
        @(posedge clk); #1;
        bus.coin_ready = 1'b0;
        pulse_refund(8'd150);
        wait_valid(20);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy",   {31'd0, bus.busy}, 32'd0);
        check("abort_valid",  {31'd0, bus.coin_valid}, 32'd0);
        check("abort_sel",    {29'd0, bus.coin_sel}, 32'd0);
        check("abort_done",   {31'd0, bus.done}, 32'd0);
        check("abort_counts", {12'd0, bus.counts}, 32'd0);
        check("abort_rem",    {24'd0, bus.remainder}, 32'd0);
        check("abort_stock",  {12'd0, bus.stock}, 32'h000F_FFFF);
        @(posedge clk); #1;
        rst_n          = 1'b1;
        bus.coin_ready = 1'b1;
        exp_coin(4); exp_coin(3);
        run_refund(8'd150, 20'h11000, 8'd0, 1'b0);
        check("stock_150", {12'd0, bus.stock}, 32'h000E_EFFF);

        repeat (2) @(posedge clk);
        check("coin_q_empty", coin_q.size(), 32'd0);
        check("done_q_empty", done_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
